// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for one pipeline-stage register: upstream (in_*)
// and downstream (out_*) sides.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 111
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready flow control, optional skid entry,
// synchronous flush and all-zero control on bubbles.
module pipe_stage_reg #(
  parameter int CTRL_W            = 9,
  parameter int DATA_W            = 111,
  parameter bit SKID              = 1'b1,
  parameter bit CLR_DATA_ON_FLUSH = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  pipe_stage_reg_if.slave        bus,
  input  logic                   flush,
  output logic [1:0]             occupancy,
  output logic [15:0]            bubble_cnt
);

  logic              r_main_valid;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_valid;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [15:0]       r_bubble_cnt;

  logic w_in_ready;
  logic w_in_xfer;
  logic w_out_xfer;

  // With a skid entry, ready comes straight from state and never from out_ready.
  assign w_in_ready = SKID ? ~r_skid_valid : (~r_main_valid | bus.out_ready);
  assign w_in_xfer  = bus.in_valid & w_in_ready;
  assign w_out_xfer = r_main_valid & bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_main_valid;
  assign bus.out_ctrl  = r_main_valid ? r_main_ctrl : '0;
  assign bus.out_data  = r_main_data;
  assign occupancy     = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
  assign bubble_cnt    = r_bubble_cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values and simulation matches the synthesized registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are reset too, because out_data must read zero after reset.
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
      r_skid_data  <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
      if (CLR_DATA_ON_FLUSH) begin
        r_main_data <= '0;
        r_skid_data <= '0;
      end
    end else if (SKID) begin
      if (!r_main_valid || w_out_xfer) begin
        if (r_skid_valid) begin
          r_main_valid <= 1'b1;
          r_main_ctrl  <= r_skid_ctrl;
          r_main_data  <= r_skid_data;
          r_skid_valid <= 1'b0;
          r_skid_ctrl  <= '0;
        end else if (w_in_xfer) begin
          r_main_valid <= 1'b1;
          r_main_ctrl  <= bus.in_ctrl;
          r_main_data  <= bus.in_data;
        end else begin
          r_main_valid <= 1'b0;
          r_main_ctrl  <= '0;
        end
      end else if (w_in_xfer) begin
        // Main is stalled: park the incoming beat behind it.
        r_skid_valid <= 1'b1;
        r_skid_ctrl  <= bus.in_ctrl;
        r_skid_data  <= bus.in_data;
      end
    end else begin
      if (w_in_xfer) begin
        r_main_valid <= 1'b1;
        r_main_ctrl  <= bus.in_ctrl;
        r_main_data  <= bus.in_data;
      end else if (w_out_xfer) begin
        r_main_valid <= 1'b0;
        r_main_ctrl  <= '0;
      end
    end
  end

  // Counts empty-output cycles; holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (!r_main_valid && r_bubble_cnt != 16'hFFFF) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1/CLR=0 and a SKID=0/CLR=1 instance share
// stimulus and are compared every cycle against a queue model of held beats.
module tb_pipe_stage_reg;
  localparam int CW = 9;
  localparam int DW = 111;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          s_rst;
  logic          s_flush;
  logic          s_in_valid;
  logic [CW-1:0] s_in_ctrl;
  logic [DW-1:0] s_in_data;
  logic          s_out_ready;

  // Index 0: SKID=0, CLR_DATA_ON_FLUSH=1.  Index 1: SKID=1, CLR_DATA_ON_FLUSH=0.
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) if0 ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) if1 ();
  logic [1:0]  occ0, occ1;
  logic [15:0] bub0, bub1;

  assign if0.in_valid  = s_in_valid;
  assign if0.in_ctrl   = s_in_ctrl;
  assign if0.in_data   = s_in_data;
  assign if0.out_ready = s_out_ready;
  assign if1.in_valid  = s_in_valid;
  assign if1.in_ctrl   = s_in_ctrl;
  assign if1.in_data   = s_in_data;
  assign if1.out_ready = s_out_ready;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0), .CLR_DATA_ON_FLUSH(1'b1)) u_s0 (
    .clk(clk), .rst(s_rst), .bus(if0.slave), .flush(s_flush),
    .occupancy(occ0), .bubble_cnt(bub0)
  );
  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CLR_DATA_ON_FLUSH(1'b0)) u_s1 (
    .clk(clk), .rst(s_rst), .bus(if1.slave), .flush(s_flush),
    .occupancy(occ1), .bubble_cnt(bub1)
  );

  logic          a_in_ready[2];
  logic          a_out_valid[2];
  logic [CW-1:0] a_out_ctrl[2];
  logic [DW-1:0] a_out_data[2];
  logic [1:0]    a_occ[2];
  logic [15:0]   a_bub[2];
  assign a_in_ready[0] = if0.in_ready;   assign a_in_ready[1] = if1.in_ready;
  assign a_out_valid[0] = if0.out_valid; assign a_out_valid[1] = if1.out_valid;
  assign a_out_ctrl[0] = if0.out_ctrl;   assign a_out_ctrl[1] = if1.out_ctrl;
  assign a_out_data[0] = if0.out_data;   assign a_out_data[1] = if1.out_data;
  assign a_occ[0] = occ0;                assign a_occ[1] = occ1;
  assign a_bub[0] = bub0;                assign a_bub[1] = bub1;

  // Model: the held beats in order (oldest first), plus the last data shown.
  beat_t         m_q[2][2];
  int            m_n[2];
  logic [DW-1:0] m_stale[2];
  int            m_bub[2];
  int            n_checks = 0;
  int            n_err = 0;

  function automatic bit m_ready(input int k);
    if (k == 1) return m_n[k] < 2;
    return m_n[k] == 0 || s_out_ready;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (s_rst) begin
        m_n[k] = 0;
        m_stale[k] = '0;
        m_bub[k] = 0;
      end else begin
        bit rdy;
        bit ox;
        bit ix;
        if (m_n[k] == 0 && m_bub[k] < 65535) m_bub[k] = m_bub[k] + 1;
        if (s_flush) begin
          m_n[k] = 0;
          if (k == 0) m_stale[k] = '0;
        end else begin
          rdy = m_ready(k);
          ox  = (m_n[k] > 0) && s_out_ready;
          ix  = s_in_valid && rdy;
          if (ox) begin
            m_q[k][0] = m_q[k][1];
            m_n[k] = m_n[k] - 1;
          end
          if (ix) begin
            m_q[k][m_n[k]] = '{ctrl: s_in_ctrl, data: s_in_data};
            m_n[k] = m_n[k] + 1;
          end
          if (m_n[k] > 0) m_stale[k] = m_q[k][0].data;
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [CW-1:0] e_ctrl;
      logic [DW-1:0] e_data;
      e_ctrl = (m_n[k] > 0) ? m_q[k][0].ctrl : '0;
      e_data = (m_n[k] > 0) ? m_q[k][0].data : m_stale[k];
      check($sformatf("k%0d_in_ready", k), 128'(a_in_ready[k]), 128'(m_ready(k)));
      check($sformatf("k%0d_out_valid", k), 128'(a_out_valid[k]), 128'(m_n[k] > 0));
      check($sformatf("k%0d_out_ctrl", k), 128'(a_out_ctrl[k]), 128'(e_ctrl));
      check($sformatf("k%0d_out_data", k), 128'(a_out_data[k]), 128'(e_data));
      check($sformatf("k%0d_occupancy", k), 128'(a_occ[k]), 128'(m_n[k]));
      check($sformatf("k%0d_bubble_cnt", k), 128'(a_bub[k]), 128'(m_bub[k]));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl);
    s_in_valid  = v;
    s_in_ctrl   = c;
    s_in_data   = d;
    s_out_ready = ordy;
    s_flush     = fl;
  endtask

  initial begin
    logic [127:0] r;
    s_rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cyc();
    cyc();
    check("rst_occ1", 128'(occ1), 128'h0);
    check("rst_bub1", 128'(bub1), 128'h0);
    check("rst_in_ready1", 128'(if1.in_ready), 128'h1);
    s_rst = 1'b0;

    // Streaming through the skid instance.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, CW'(i), DW'(i), 1'b1, 1'b0);
      cyc();
      check("stream_data", 128'(if1.out_data), 128'(i));
      check("stream_occ", 128'(occ1), 128'h1);
      check("stream_rdy", 128'(if1.in_ready), 128'h1);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cyc();

    // Back-pressure.
    drive(1'b1, 9'h3, DW'(8'hA), 1'b0, 1'b0);
    cyc();
    drive(1'b1, 9'h5, DW'(8'hB), 1'b0, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cyc();
    check("bp_occ1", 128'(occ1), 128'h2);
    check("bp_rdy1", 128'(if1.in_ready), 128'h0);
    check("bp_data1", 128'(if1.out_data), 128'hA);
    check("bp_rdy0", 128'(if0.in_ready), 128'h0);
    check("bp_data0", 128'(if0.out_data), 128'hA);
    drive(1'b1, 9'h7, DW'(8'hD), 1'b1, 1'b0);
    #1;
    check("comb_rdy0", 128'(if0.in_ready), 128'h1);
    check("reg_rdy1", 128'(if1.in_ready), 128'h0);
    cyc();
    check("drain_data1", 128'(if1.out_data), 128'hB);
    check("drain_occ1", 128'(occ1), 128'h1);
    check("drain_rdy1", 128'(if1.in_ready), 128'h1);
    check("replace_data0", 128'(if0.out_data), 128'hD);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cyc();

    // Flush while full, with a beat offered in the same cycle.
    drive(1'b1, 9'h1FF, DW'(8'h11), 1'b0, 1'b0);
    cyc();
    drive(1'b1, 9'h1FF, DW'(8'h22), 1'b0, 1'b0);
    cyc();
    drive(1'b1, 9'h1FF, DW'(8'hC), 1'b0, 1'b1);
    cyc();
    check("flush_valid1", 128'(if1.out_valid), 128'h0);
    check("flush_ctrl1", 128'(if1.out_ctrl), 128'h0);
    check("flush_occ1", 128'(occ1), 128'h0);
    check("flush_stale1", 128'(if1.out_data), 128'h11);
    check("flush_clr0", 128'(if0.out_data), 128'h0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("flush_no_c", 128'(if1.out_valid), 128'h0);
    end

    // Reset while holding two beats, then saturate the bubble counter.
    drive(1'b1, 9'h1A, DW'(8'h33), 1'b0, 1'b0);
    cyc();
    drive(1'b1, 9'h1B, DW'(8'h44), 1'b0, 1'b0);
    cyc();
    check("pre_rst_occ1", 128'(occ1), 128'h2);
    s_rst = 1'b1;
    cyc();
    s_rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("mid_rst_valid1", 128'(if1.out_valid), 128'h0);
    check("mid_rst_data1", 128'(if1.out_data), 128'h0);
    check("mid_rst_bub1", 128'(bub1), 128'h0);
    for (int i = 0; i < 70000; i++) cyc();
    check("sat_bub1", 128'(bub1), 128'hFFFF);
    check("sat_bub0", 128'(bub0), 128'hFFFF);
    cyc();
    check("sat_hold1", 128'(bub1), 128'hFFFF);

    // Random valid/ready traffic without flush.
    for (int i = 0; i < 10000; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      drive(1'($urandom_range(0, 1)), CW'($urandom()), r[DW-1:0],
            1'($urandom_range(0, 2) != 0), 1'b0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline-stage register for the MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds valid/ready flow control, an optional 2-entry skid buffer, synchronous flush, and NOP-bubble insertion.
- Control fields (WB/M/EX) are carried separately from the datapath so that bubbles always present all-zero control.
- Sits between two pipeline stages. The hazard unit drives flush; downstream back-pressure drives out_ready.

Parameters:
- CTRL_W, 9, control-field width (WB 2 + M 3 + EX 4 in the ID/EX instance).
- DATA_W, 111, datapath width (3x32 operands/immediate + 3x5 register IDs in the ID/EX instance).
- SKID, 1, 0 = single register with combinational ready; 1 = main + skid entry with registered ready.
- CLR_DATA_ON_FLUSH, 0, 1 = flush also zeroes the data registers; 0 = data holds its stale value.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, upstream beat present.
- in_ready, output, 1, stage can accept a beat this cycle.
- in_ctrl, input, CTRL_W, upstream control field.
- in_data, input, DATA_W, upstream datapath field.
- out_valid, output, 1, downstream beat present.
- out_ready, input, 1, downstream accepts this cycle.
- out_ctrl, output, CTRL_W, control field; all-zero whenever out_valid=0.
- out_data, output, DATA_W, datapath field.
- flush, input, 1, kill all held beats (branch mispredict / exception).
- occupancy, output, 2, number of held beats (0..2; max 1 when SKID=0).
- bubble_cnt, output, 16, saturating count of cycles with out_valid=0.

Behaviour:
- Handshake: an input transfer occurs when in_valid & in_ready; an output transfer when out_valid & out_ready. Beats stay in order; the stage never drops or duplicates a beat except on flush.
- Reset (rst=1 at clk edge): out_valid=0, out_ctrl=0, out_data=0, skid entry empty and zeroed, occupancy=0, bubble_cnt=0. With SKID=1, in_ready=1 from the first cycle after reset. Reset overrides flush and any handshake.
- Latency: 1 cycle. A beat accepted at edge N appears on out_* after edge N if the stage was empty or draining.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - On input transfer, main <= in. Otherwise, on output transfer, out_valid <= 0.
- SKID=1:
  - in_ready = ~skid_valid, taken directly from a flop (no combinational path from out_ready).
  - Main empty or output transfer this cycle:
    - Skid valid: main <= skid, skid emptied.
    - Else, input transfer: main <= in.
    - Else: main emptied.
  - Main valid, no output transfer, and an input transfer: skid <= in.
  - Skid valid always implies main valid.
- Bubble rule: out_ctrl is forced to 0 whenever out_valid=0. The control register itself is cleared whenever the main entry is emptied. out_data holds its last value unless CLR_DATA_ON_FLUSH=1.
- Flush (synchronous, priority over everything except rst):
  - Main and skid valid <= 0; control registers <= 0; data registers <= 0 only if CLR_DATA_ON_FLUSH=1.
  - Any input beat presented in the flush cycle is discarded, even if in_ready=1.
  - Any output transfer in the flush cycle still counts downstream, since out_* was valid that cycle.
  - occupancy = 0 on the next cycle.
- occupancy = main_valid + skid_valid.
- bubble_cnt increments on every edge where out_valid=0 and rst=0, and saturates at 16'hFFFF (no wrap).
- Simultaneous events:
  - With SKID=1, full (occupancy 2) and out_ready=1: main <= skid, occupancy goes to 1, in_ready rises the next cycle. No input is taken that cycle.
  - Empty stage, in_valid=1: the beat is accepted and out_valid=1 next cycle regardless of out_ready.
- Reset or flush while holding 2 beats: both are lost; no partial state remains.

Test Plan:
- Streaming (SKID=1): in_valid=1 with in_data=1,2,3,4 on consecutive cycles, out_ready=1 -> out_data=1,2,3,4 one cycle later; occupancy=1 throughout; in_ready stays 1.
- Back-pressure: send 0xA, 0xB; hold out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA held. Raise out_ready -> 0xA then 0xB emerge; in_ready=1 one cycle after the first drain.
- Flush: stage full with ctrl=9'h1FF; assert flush together with in_valid=1 (in_data=0xC) -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 0xC never appears at the output.
- SKID=0 instance: out_ready=0 with a beat held -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 combinationally, and the next beat replaces the current one at the edge.
- Reset mid-operation: rst=1 while occupancy=2 -> out_valid=0, out_data=0, bubble_cnt=0 next cycle. Then idle 70000 cycles -> bubble_cnt=16'hFFFF, held there.
- Random valid/ready with a scoreboard (10k cycles, no flush) -> output sequence matches input order exactly; out_ctrl=0 on every out_valid=0 cycle.
